// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Operation codes follow the low two bits of the MIPS funct field.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_FIX  = 2'b10;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFFFFFF;

    function automatic logic op_is_div(input logic [1:0] f_op);
        return f_op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] f_op);
        return ~f_op[0];
    endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division iteration: shift {rem, quot} left, trial-subtract
// the divisor and keep the difference only when it does not borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quot,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quot
);

    logic [WIDTH:0]   w_shifted;
    logic [WIDTH+1:0] w_diff;
    logic             w_fits;
    logic [WIDTH:0]   w_sel;
    logic             w_unused_top;

    assign w_shifted = {i_rem, i_quot[WIDTH-1]};
    assign w_diff    = {1'b0, w_shifted} - {2'b00, i_divisor};
    assign w_fits    = ~w_diff[WIDTH+1];

    // The kept remainder is always below the divisor, so its top bit is zero.
    assign w_sel        = w_fits ? w_diff[WIDTH:0] : w_shifted;
    assign w_unused_top = w_sel[WIDTH];
    assign o_rem        = w_sel[WIDTH-1:0];
    assign o_quot       = {i_quot[WIDTH-2:0], w_fits};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS mult/multu/div/divu unit with HI/LO and mthi/mtlo.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply path.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_b_zero;
    logic [WIDTH-1:0] r_a_raw;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q;

    logic             w_launch;
    logic             w_sgn;
    logic [WIDTH:0]   w_addend;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_quot_nx;
    logic [2*WIDTH-1:0] w_prod_mag;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_quot_fix;
    logic [WIDTH-1:0] w_rem_fix;

    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] f_apply_sign(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] f_apply_sign2(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign w_launch = (r_state == ST_IDLE) && start;
    assign w_sgn    = op_is_signed(op);

    // Shift-add multiply: accumulator sits above the shifting multiplier.
    assign w_addend = r_q[0] ? {1'b0, r_divisor} : '0;
    assign w_sum    = r_acc + w_addend;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .i_rem     (r_acc[WIDTH-1:0]),
        .i_quot    (r_q),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_nx),
        .o_quot    (w_quot_nx)
    );

`ifdef MULDIV_FAST_MUL_EN
    assign w_prod_mag = {{WIDTH{1'b0}}, r_q} * {{WIDTH{1'b0}}, r_divisor};
`else
    assign w_prod_mag = {r_acc[WIDTH-1:0], r_q};
`endif

    assign w_prod     = f_apply_sign2(w_prod_mag, r_neg_q);
    assign w_quot_fix = r_b_zero ? DIV0_QUOT : f_apply_sign(r_q, r_neg_q);
    assign w_rem_fix  = r_b_zero ? r_a_raw : f_apply_sign(r_acc[WIDTH-1:0], r_neg_r);

    // Control and architectural HI/LO state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                        r_state <= op_is_div(op) ? ST_RUN : ST_FIX;
`else
                        r_state <= ST_RUN;
`endif
                    end else begin
                        if (mthi_we) r_hi <= wdata;
                        if (mtlo_we) r_lo <= wdata;
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= ST_FIX;
                end
                ST_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quot_fix;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Datapath: operands captured as magnitudes, then one step per RUN cycle.
    always_ff @(posedge clk) begin
        if (w_launch) begin
            r_is_div  <= op_is_div(op);
            r_neg_q   <= w_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_r   <= w_sgn & a[WIDTH-1];
            r_b_zero  <= (b == '0);
            r_a_raw   <= a;
            r_q       <= f_mag(a, w_sgn);
            r_divisor <= f_mag(b, w_sgn);
            r_acc     <= '0;
        end else if (r_state == ST_RUN) begin
            if (r_is_div) begin
                r_acc <= {1'b0, w_rem_nx};
                r_q   <= w_quot_nx;
            end else begin
                r_acc <= {1'b0, w_sum[WIDTH:1]};
                r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, randomized ops against
// a plain-arithmetic model, HI/LO writes, collisions, back-to-back and reset.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi_we;
    logic        mtlo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] h;
        logic [31:0] l;
    } vec_t;

    vec_t dir [0:9] = '{
        '{2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB},
        '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
        '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
        '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14},
        '{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF},
        '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
        '{2'b10, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF},
        '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
        '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD},
        '{2'b00, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000}
    };

    muldiv_unit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .mthi_we (mthi_we),
        .mtlo_we (mtlo_we),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    // Returns {hi, lo} as the ISA defines them.
    function automatic logic [63:0] ref_muldiv(input logic [1:0] f_op, input logic [31:0] fa, input logic [31:0] fb);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        logic [31:0] uq;
        logic [31:0] ur;
        sa = longint'($signed(fa));
        sb = longint'($signed(fb));
        p  = 64'd0;
        case (f_op)
            2'b00: p = sa * sb;
            2'b01: p = {32'd0, fa} * {32'd0, fb};
            2'b10: begin
                if (fb == 32'd0) p = {fa, 32'hFFFFFFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (fb == 32'd0) p = {fa, 32'hFFFFFFFF};
                else begin
                    uq = fa / fb;
                    ur = fa % fb;
                    p  = {ur, uq};
                end
            end
        endcase
        return p;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] corner [0:4];
        corner[0] = 32'h00000000;
        corner[1] = 32'h00000001;
        corner[2] = 32'hFFFFFFFF;
        corner[3] = 32'h80000000;
        corner[4] = 32'h7FFFFFFF;
        case ($urandom_range(0, 5))
            0:       return corner[$urandom_range(0, 4)];
            1:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_done(input int lat, input int inj, input string name);
        int cyc;
        bit seen;
        bit bad;
        cyc  = 0;
        seen = 0;
        bad  = 0;
        while (!seen && cyc <= 60) begin
            @(negedge clk);
            if (cyc == 0) begin
                start   = 1'b0;
                mthi_we = 1'b0;
                mtlo_we = 1'b0;
                a       = $urandom;
                b       = $urandom;
            end
            if (done === 1'b1) seen = 1;
            else begin
                if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo) bad = 1;
                if (cyc == inj) begin
                    start   = 1'b1;
                    op      = 2'b01;
                    mthi_we = 1'b1;
                    wdata   = 32'hDEADBEEF;
                end else if (cyc == inj + 1) begin
                    start   = 1'b0;
                    mthi_we = 1'b0;
                end
                cyc++;
            end
        end
        n_cmp++;
        if (!seen || cyc != lat) begin
            n_err++;
            $display("FAIL %s latency: actual=%0d required=%0d (done seen=%0b)", name, cyc, lat, seen);
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL %s busy/hold: busy low or hi/lo changed before done (hi=%h lo=%h required hi=%h lo=%h)",
                     name, hi, lo, m_hi, m_lo);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s busy_at_done: actual=%b required=0", name, busy);
        end
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int inj, input string name);
        logic [63:0] e;
        int          lat;
        e     = ref_muldiv(o, x, y);
        lat   = o[1] ? DIV_LAT : MUL_LAT;
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        wait_done(lat, inj, name);
        n_cmp++;
        if (hi !== e[63:32]) begin
            n_err++;
            $display("FAIL %s hi: op=%0d a=%h b=%h actual=%h required=%h", name, o, x, y, hi, e[63:32]);
        end
        n_cmp++;
        if (lo !== e[31:0]) begin
            n_err++;
            $display("FAIL %s lo: op=%0d a=%h b=%h actual=%h required=%h", name, o, x, y, lo, e[31:0]);
        end
        m_hi = e[63:32];
        m_lo = e[31:0];
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        a       = 32'd0;
        b       = 32'd0;
        mthi_we = 1'b0;
        mtlo_we = 1'b0;
        wdata   = 32'd0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h required 0/0/0/0", busy, done, hi, lo);
        end
        rst  = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        for (int i = 0; i < 10; i++) begin
            do_op(dir[i].op, dir[i].a, dir[i].b, -1, $sformatf("directed%0d", i));
            n_cmp++;
            if (hi !== dir[i].h || lo !== dir[i].l) begin
                n_err++;
                $display("FAIL directed%0d_table: actual hi=%h lo=%h required hi=%h lo=%h",
                         i, hi, lo, dir[i].h, dir[i].l);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            x = pick_operand();
            y = pick_operand();
            do_op(o, x, y, -1, $sformatf("random%0d", i));
        end
    endtask

    task automatic test_mt();
        mthi_we = 1'b1;
        wdata   = 32'hDEADBEEF;
        @(negedge clk);
        mthi_we = 1'b0;
        n_cmp++;
        if (hi !== 32'hDEADBEEF || lo !== m_lo) begin
            n_err++;
            $display("FAIL mthi_idle: actual hi=%h lo=%h required hi=DEADBEEF lo=%h", hi, lo, m_lo);
        end
        m_hi    = 32'hDEADBEEF;
        mtlo_we = 1'b1;
        wdata   = 32'h12345678;
        @(negedge clk);
        mtlo_we = 1'b0;
        n_cmp++;
        if (hi !== m_hi || lo !== 32'h12345678) begin
            n_err++;
            $display("FAIL mtlo_idle: actual hi=%h lo=%h required hi=%h lo=12345678", hi, lo, m_hi);
        end
        m_lo    = 32'h12345678;
        mthi_we = 1'b1;
        mtlo_we = 1'b1;
        wdata   = 32'hCAFEF00D;
        @(negedge clk);
        mthi_we = 1'b0;
        mtlo_we = 1'b0;
        n_cmp++;
        if (hi !== 32'hCAFEF00D || lo !== 32'hCAFEF00D) begin
            n_err++;
            $display("FAIL mthi_mtlo_both: actual hi=%h lo=%h required CAFEF00D/CAFEF00D", hi, lo);
        end
        m_hi = 32'hCAFEF00D;
        m_lo = 32'hCAFEF00D;
        // Start and writes in the same idle cycle: writes must be dropped.
        mthi_we = 1'b1;
        mtlo_we = 1'b1;
        wdata   = 32'h11111111;
        do_op(2'b01, 32'd3, 32'd5, -1, "start_wins");
    endtask

    task automatic test_collision();
        do_op(2'b10, 32'hFFFFFF9C, 32'd7, 4, "collision_div");
        n_cmp++;
        if (hi !== 32'hFFFFFFFE || lo !== 32'hFFFFFFF2) begin
            n_err++;
            $display("FAIL collision_result: actual hi=%h lo=%h required FFFFFFFE/FFFFFFF2", hi, lo);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== m_hi) begin
            n_err++;
            $display("FAIL collision_after: busy=%b done=%b hi=%h required 0/0/%h", busy, done, hi, m_hi);
        end
    endtask

    task automatic test_back_to_back();
        do_op(2'b01, 32'h0000FFFF, 32'h00010001, -1, "b2b_first");
        do_op(2'b11, 32'hFFFFFFFF, 32'h00000010, -1, "b2b_second");
        do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, "b2b_third");
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL done_one_cycle: actual=%b required=0", done);
        end
    endtask

    task automatic test_reset_midop();
        bit stray;
        op    = 2'b11;
        a     = 32'd1000;
        b     = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_err++;
            $display("FAIL reset_midop: busy=%b done=%b hi=%h lo=%h required 0/0/0/0", busy, done, hi, lo);
        end
        rst   = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) stray = 1;
        end
        n_cmp++;
        if (stray) begin
            n_err++;
            $display("FAIL reset_discard: aborted op still produced activity (busy=%b done=%b hi=%h lo=%h)",
                     busy, done, hi, lo);
        end
        do_op(2'b01, 32'd3, 32'd5, -1, "after_reset");
        n_cmp++;
        if (hi !== 32'd0 || lo !== 32'd15) begin
            n_err++;
            $display("FAIL after_reset_table: actual hi=%h lo=%h required 0/15", hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mt();
        test_collision();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit sitting directly downstream of regfile32x32 read ports.
- Operands come straight from readdata1/readdata2; results go to internal HI/LO registers, later moved to the register file via mfhi/mflo.
- Implements MIPS mult, multu, div, divu, mthi and mtlo, with a start/busy/done handshake toward the pipeline control.

Parameters:
- WIDTH, 32, operand and HI/LO width. Only 32 needs to be supported.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; everything is sampled on the posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  launch the operation given by op; sampled only when idle.
- op  input  2  operation select: 00 mult, 01 multu, 10 div, 11 divu.
- a  input  WIDTH  operand rs (from readdata1).
- b  input  WIDTH  operand rt (from readdata2).
- mthi_we  input  1  write wdata into HI.
- mtlo_we  input  1  write wdata into LO.
- wdata  input  WIDTH  data for mthi/mtlo.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; HI/LO are valid in the same cycle.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
Reset and ownership
- rst = 1 at a posedge puts the FSM in IDLE and sets hi = lo = 0, busy = 0, done = 0, counter = 0.
- rst overrides everything, including an operation in flight; the partial result is discarded.
- hi and lo change only in FIX or through an idle mthi/mtlo write.

FSM states: IDLE, RUN, FIX
- IDLE: start = 1 at edge E0 latches a, b and op, converts signed operands to magnitudes, clears the accumulator, and moves to RUN with busy = 1.
- RUN: one shift-add step (multiply) or one restoring-subtract step (divide) per edge on E1..E32. The counter counts WIDTH iterations, then moves to FIX.
- FIX (edge E33): applies sign correction and writes hi/lo. done = 1 and busy = 0 for the cycle after E33, then returns to IDLE.
- Handshake: done is high for exactly one cycle. A start in that same cycle is accepted, since the FSM is already in IDLE.

Result rules
- Multiply: {hi, lo} = full 64-bit product; signed for mult, unsigned for multu.
- Divide: lo = quotient, hi = remainder, with truncation toward zero.
  - Signed quotient sign = sign(a) XOR sign(b); signed remainder takes the sign of a.
  - div 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0 (wraps, no trap).
- Divide by zero (div or divu, b = 0): lo = 0xFFFFFFFF, hi = a unmodified. Same latency as a normal divide.

Collisions and ignored inputs
- start while busy: ignored; no state change.
- mthi_we / mtlo_we while busy: ignored.
- mthi_we / mtlo_we when idle: HI/LO updated at the next edge.
- start together with mthi_we/mtlo_we in IDLE: start wins and the writes are dropped.
- mthi_we and mtlo_we together in IDLE: both registers are written with wdata.
- Operand inputs are don't-care except at the start edge.

Optional Feature:
- MULDIV_FAST_MUL_EN defined: mult/multu use a single combinational WIDTH x WIDTH multiplier. The start edge E0 goes to FIX; hi/lo are written at E1 and done pulses in the cycle after E1. Divide is unchanged.
- MULDIV_FAST_MUL_EN undefined: all operations are iterative with 33-edge latency; no hardware multiplier is inferred.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - FSM state encoding;
  - constant DIV0_QUOT = 32'hFFFFFFFF.
- One natural sub-module: div_step. It is purely combinational and performs one restoring iteration: {rem, quot} in, {rem', quot'} out. muldiv_unit instantiates it once, inside RUN.

Test Plan:
1. mult a = 0x00000007, b = 0xFFFFFFFD, start at E0 -> busy E0..E33, done one cycle after E33; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
2. multu 0xFFFFFFFF x 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001. Repeat with MULDIV_FAST_MUL_EN: same values, done after E1.
3. div 0xFFFFFFF9 (-7) / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; divu 100 / 7 -> lo = 14, hi = 2.
4. divu 0x00001234 / 0 -> lo = 0xFFFFFFFF, hi = 0x00001234; div 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
5. Collisions:
   - second start and mthi_we (wdata = 0xDEADBEEF) at E5 of a running div -> both ignored; the original result is delivered.
   - mthi_we with 0xDEADBEEF when idle -> hi = 0xDEADBEEF next cycle.
6. rst = 1 at E10 of a divu -> busy = 0, done = 0, hi = lo = 0 next cycle; a fresh multu 3 x 5 then yields lo = 15, hi = 0.
